control_sequencer: RTL and testbench
====================================

# control_sequencer

Parametrised multi-step control sequencer for the datapath control unit. It generalises the fixed four-state start-triggered controller to a programmable table of NUM_STEPS steps per mode. Each step has its own control word and dwell time. A sequence is launched by `start`, runs with `mode` latched for its full duration, can be aborted, and signals completion with a one-cycle `done` pulse. The block sits between the top-level command logic and the datapath control inputs.

## Interface

Parameters:

- CTRL_W, 4, control word width.
- NUM_STEPS, 4, steps per sequence; must be ≥2.
- MODE_W, 1, mode select width; the table holds 2^MODE_W independent sequences.
- HOLD_W, 4, width of the per-step dwell field.
- STEP_W, $clog2(NUM_STEPS), step index width; derived, not overridden.

Ports:

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- abort  in  1  terminate the running sequence.
- mode  in  MODE_W  sequence select; latched on accepted start.
- cfg_we  in  1  table write enable.
- cfg_mode  in  MODE_W  table write mode index.
- cfg_step  in  STEP_W  table write step index.
- cfg_word  in  CTRL_W  control word to store.
- cfg_hold  in  HOLD_W  dwell value to store; the step lasts cfg_hold+1 cycles.
- out  out  CTRL_W  registered control word to the datapath.
- step  out  STEP_W  index of the active step; 0 when not running.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on normal completion.

## Operation

States:

- IDLE: out=0, busy=0, step=0.
  - start=1 → RUN, with mode_q←mode, step←0, out←word[mode][0], dwell counter←hold[mode][0].
- RUN: busy=1; out holds the word loaded at step entry.
  - The dwell counter decrements each cycle.
  - When the counter is 0 and step<NUM_STEPS-1: step←step+1, and out/counter load from the table entry [mode_q][step+1].
  - When the counter is 0 and step=NUM_STEPS-1: go to DONE.
- DONE: out=0, busy=0, done=1, step=0, for exactly one cycle, then IDLE.
  - start during DONE is ignored.

Rules:

- abort has priority over dwell expiry and step advance. abort=1 in RUN → IDLE next edge: out=0, busy=0, done stays 0.
- abort in IDLE or DONE has no effect.
- start while busy=1 or in DONE is ignored.
- mode changes during RUN have no effect; only mode_q is used.
- Table storage:
  - 2^MODE_W × NUM_STEPS entries, each CTRL_W+HOLD_W bits.
  - Writes occur on any cycle with cfg_we=1, regardless of state.
  - cfg_step ≥ NUM_STEPS → write dropped.
- A table write does not change out for a step already entered; it takes effect on the next entry to that step.
- Write and read of the same entry on the same edge: the step entry loads the old value (read-before-write).
- The dwell counter is HOLD_W bits with no wrap. The maximum hold (2^HOLD_W−1) gives 2^HOLD_W cycles.

## Timing

- Reset, asserted asynchronously, forces immediately:
  - state IDLE, out=0, step=0, busy=0, done=0, mode_q=0, dwell counter=0.
  - All table entries cleared: word=0, hold=0.
- Reset mid-sequence aborts without a done pulse.
- Outputs are registered, with no combinational path from inputs to outputs.
- start high at edge n in IDLE → at edge n: busy=1 and out=word[mode][0] become visible.
- Step i is visible for hold_i+1 cycles.
- done is visible in the cycle after the last step's final cycle.
- Total from the accepting edge to the rising of done: Σ(hold_i+1) cycles.
- Back-to-back sequences: earliest next acceptance is the edge ending the DONE cycle plus one, i.e. one idle cycle minimum after DONE.

## Test plan

- Reset defaults:
  - Stimulus: assert reset mid-RUN, then check state.
  - Response: out=0, busy=0, done=0, step=0 immediately.
  - Then start with an empty table → 4 steps of out=0, each 1 cycle, then done after 4 cycles.
- Programmed mode 0:
  - Stimulus: words {0x0,0x2,0xA,0xA}, holds {0,0,0,0}; start with mode=0.
  - Response: out sequence 0x0,0x2,0xA,0xA on consecutive cycles, then done=1 for one cycle, then IDLE.
- Mode latch and dwell:
  - Stimulus: mode 1 words {0x1,0x2,0x4,0xB}, holds {2,0,1,0}; start with mode=1; toggle mode during RUN.
  - Response: 0x1×3, 0x2×1, 0x4×2, 0xB×1, then done; the mode toggle has no effect.
- Abort:
  - Stimulus: abort=1 during step 2 of the previous sequence.
  - Response: next edge out=0, busy=0, done never asserted.
  - Stimulus: start=1 held through RUN and DONE.
  - Response: no restart until IDLE.
- Table write races:
  - Stimulus: write step 3 while step 3 is active.
  - Response: out is unchanged until the next sequence.
  - Stimulus: write on the same edge as step entry.
  - Response: old value is used.
  - Stimulus: cfg_step=NUM_STEPS.
  - Response: the table is unchanged.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: programmable per-mode step table driving registered datapath control words
module control_sequencer #(
  parameter int CTRL_W = 4,
  parameter int NUM_STEPS = 4,
  parameter int MODE_W = 1,
  parameter int HOLD_W = 4,
  localparam int STEP_W = $clog2(NUM_STEPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [MODE_W-1:0] mode,
  input  logic              cfg_we,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [CTRL_W-1:0] cfg_word,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic [CTRL_W-1:0] out,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done
);
  localparam int ENT = (2 ** MODE_W) * NUM_STEPS;
  localparam int IDX_W = $clog2(ENT);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t state, state_n;
  logic [CTRL_W+HOLD_W-1:0] tbl [ENT];
  logic [CTRL_W+HOLD_W-1:0] rd_ent;
  logic [MODE_W-1:0] mode_q, mode_n, rd_mode;
  logic [STEP_W-1:0] step_n, rd_step;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [CTRL_W-1:0] out_n;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic wr_ok;
  // Table lookup for the entry about to be entered: step 0 of the requested mode in IDLE, the next step of the latched mode in RUN
  always_comb begin
    rd_mode = (state == S_IDLE) ? mode : mode_q;
    rd_step = (state == S_IDLE) ? '0 : step + 1'b1;
    rd_idx = IDX_W'(32'(rd_mode) * NUM_STEPS + 32'(rd_step));
    rd_ent = tbl[rd_idx];
    wr_idx = IDX_W'(32'(cfg_mode) * NUM_STEPS + 32'(cfg_step));
    wr_ok = cfg_we && (32'(cfg_step) < NUM_STEPS);
  end
  // Next-state and next-output logic; abort outranks dwell expiry and step advance
  always_comb begin
    state_n = state;
    mode_n = mode_q;
    step_n = step;
    cnt_n = cnt;
    out_n = out;
    if (state == S_IDLE) begin
      if (start) begin
        state_n = S_RUN;
        mode_n = mode;
        step_n = '0;
        out_n = rd_ent[CTRL_W+HOLD_W-1:HOLD_W];
        cnt_n = rd_ent[HOLD_W-1:0];
      end
    end else if (state == S_RUN) begin
      if (abort) begin
        state_n = S_IDLE;
        step_n = '0;
        out_n = '0;
        cnt_n = '0;
      end else if (cnt != '0) begin
        cnt_n = cnt - 1'b1;
      end else if (32'(step) == NUM_STEPS - 1) begin
        state_n = S_FIN;
        step_n = '0;
        out_n = '0;
      end else begin
        step_n = step + 1'b1;
        out_n = rd_ent[CTRL_W+HOLD_W-1:HOLD_W];
        cnt_n = rd_ent[HOLD_W-1:0];
      end
    end else begin
      state_n = S_IDLE;
    end
  end
  // Sequencer state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      mode_q <= '0;
      step <= '0;
      cnt <= '0;
      out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      mode_q <= mode_n;
      step <= step_n;
      cnt <= cnt_n;
      out <= out_n;
      busy <= (state_n == S_RUN);
      done <= (state_n == S_FIN);
    end
  end
  // Step table; out-of-range step writes are dropped so they cannot alias into another mode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENT; i++) tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[wr_idx] <= {cfg_word, cfg_hold};
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer
module tb_control_sequencer;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, cfg_we = 1'b0;
  logic [0:0] mode = '0, cfg_mode = '0;
  logic [1:0] cfg_step = '0;
  logic [3:0] cfg_word = '0, cfg_hold = '0;
  logic [3:0] out, out3;
  logic [1:0] step, step3;
  logic busy, done, busy3, done3;
  int vecs = 0, errs = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_step(cfg_step), .cfg_word(cfg_word),
    .cfg_hold(cfg_hold), .out(out), .step(step), .busy(busy), .done(done)
  );

  control_sequencer #(.NUM_STEPS(3)) dut3 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_step(cfg_step), .cfg_word(cfg_word),
    .cfg_hold(cfg_hold), .out(out3), .step(step3), .busy(busy3), .done(done3)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic ex(string tag, logic [3:0] o, logic [1:0] s, logic b, logic d);
    vecs++;
    assert ({out, step, busy, done} === {o, s, b, d}) else begin
      errs++;
      $error("FAIL %s observed out/step/busy/done=%h/%h/%b/%b expected %h/%h/%b/%b",
             tag, out, step, busy, done, o, s, b, d);
    end
  endtask

  task automatic ex3(string tag, logic [3:0] o, logic [1:0] s, logic b, logic d);
    vecs++;
    assert ({out3, step3, busy3, done3} === {o, s, b, d}) else begin
      errs++;
      $error("FAIL %s observed out/step/busy/done=%h/%h/%b/%b expected %h/%h/%b/%b",
             tag, out3, step3, busy3, done3, o, s, b, d);
    end
  endtask

  task automatic st(string tag, logic [3:0] o, logic [1:0] s, logic b, logic d);
    tick;
    ex(tag, o, s, b, d);
  endtask

  task automatic cfg(logic [0:0] m, logic [1:0] s, logic [3:0] w, logic [3:0] h);
    cfg_we = 1'b1; cfg_mode = m; cfg_step = s; cfg_word = w; cfg_hold = h;
    tick;
    cfg_we = 1'b0;
  endtask

  initial begin
    tick;
    ex("reset_defaults", 4'h0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b1; st("empty_acc", 4'h0, 2'd0, 1'b1, 1'b0); start = 1'b0;
    st("empty_s1", 4'h0, 2'd1, 1'b1, 1'b0);
    st("empty_s2", 4'h0, 2'd2, 1'b1, 1'b0);
    st("empty_s3", 4'h0, 2'd3, 1'b1, 1'b0);
    st("empty_done", 4'h0, 2'd0, 1'b0, 1'b1);
    st("empty_idle", 4'h0, 2'd0, 1'b0, 1'b0);
    start = 1'b1; st("pre_rst_acc", 4'h0, 2'd0, 1'b1, 1'b0); start = 1'b0;
    st("pre_rst_s1", 4'h0, 2'd1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 ex("async_reset", 4'h0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    st("post_reset_idle", 4'h0, 2'd0, 1'b0, 1'b0);

    cfg(1'b0, 2'd0, 4'h0, 4'd0); cfg(1'b0, 2'd1, 4'h2, 4'd0);
    cfg(1'b0, 2'd2, 4'hA, 4'd0); cfg(1'b0, 2'd3, 4'hA, 4'd0);
    cfg(1'b1, 2'd0, 4'h1, 4'd2); cfg(1'b1, 2'd1, 4'h2, 4'd0);
    cfg(1'b1, 2'd2, 4'h4, 4'd1); cfg(1'b1, 2'd3, 4'hB, 4'd0);

    mode = 1'b0; start = 1'b1; st("m0_s0", 4'h0, 2'd0, 1'b1, 1'b0); start = 1'b0;
    st("m0_s1", 4'h2, 2'd1, 1'b1, 1'b0);
    st("m0_s2", 4'hA, 2'd2, 1'b1, 1'b0);
    st("m0_s3", 4'hA, 2'd3, 1'b1, 1'b0);
    st("m0_done", 4'h0, 2'd0, 1'b0, 1'b1);
    st("m0_idle", 4'h0, 2'd0, 1'b0, 1'b0);

    mode = 1'b1; start = 1'b1; st("m1_s0a", 4'h1, 2'd0, 1'b1, 1'b0); start = 1'b0;
    mode = 1'b0;
    st("m1_s0b", 4'h1, 2'd0, 1'b1, 1'b0);
    st("m1_s0c", 4'h1, 2'd0, 1'b1, 1'b0);
    st("m1_s1", 4'h2, 2'd1, 1'b1, 1'b0);
    mode = 1'b1;
    st("m1_s2a", 4'h4, 2'd2, 1'b1, 1'b0);
    st("m1_s2b", 4'h4, 2'd2, 1'b1, 1'b0);
    st("m1_s3", 4'hB, 2'd3, 1'b1, 1'b0);
    st("m1_done", 4'h0, 2'd0, 1'b0, 1'b1);
    st("m1_idle", 4'h0, 2'd0, 1'b0, 1'b0);

    mode = 1'b0; start = 1'b1;
    st("hold_s0", 4'h0, 2'd0, 1'b1, 1'b0);
    st("hold_s1", 4'h2, 2'd1, 1'b1, 1'b0);
    st("hold_s2", 4'hA, 2'd2, 1'b1, 1'b0);
    st("hold_s3", 4'hA, 2'd3, 1'b1, 1'b0);
    st("hold_done", 4'h0, 2'd0, 1'b0, 1'b1);
    st("hold_idle", 4'h0, 2'd0, 1'b0, 1'b0);
    st("hold_restart", 4'h0, 2'd0, 1'b1, 1'b0);
    st("hold_re_s1", 4'h2, 2'd1, 1'b1, 1'b0);
    st("hold_re_s2", 4'hA, 2'd2, 1'b1, 1'b0);
    abort = 1'b1; start = 1'b0;
    st("abort_idle", 4'h0, 2'd0, 1'b0, 1'b0);
    abort = 1'b0;
    st("abort_no_done", 4'h0, 2'd0, 1'b0, 1'b0);

    abort = 1'b1; start = 1'b1;
    st("abort_in_idle_acc", 4'h0, 2'd0, 1'b1, 1'b0);
    abort = 1'b0; start = 1'b0;
    st("ai_s1", 4'h2, 2'd1, 1'b1, 1'b0);
    st("ai_s2", 4'hA, 2'd2, 1'b1, 1'b0);
    st("ai_s3", 4'hA, 2'd3, 1'b1, 1'b0);
    st("ai_done", 4'h0, 2'd0, 1'b0, 1'b1);
    st("ai_idle", 4'h0, 2'd0, 1'b0, 1'b0);

    mode = 1'b1; start = 1'b1; st("w_s0a", 4'h1, 2'd0, 1'b1, 1'b0); start = 1'b0;
    st("w_s0b", 4'h1, 2'd0, 1'b1, 1'b0);
    st("w_s0c", 4'h1, 2'd0, 1'b1, 1'b0);
    cfg_we = 1'b1; cfg_mode = 1'b1; cfg_step = 2'd1; cfg_word = 4'h9; cfg_hold = 4'd0;
    st("w_entry1_old", 4'h2, 2'd1, 1'b1, 1'b0);
    cfg_step = 2'd2; cfg_word = 4'h6;
    st("w_entry2_old", 4'h4, 2'd2, 1'b1, 1'b0);
    cfg_word = 4'h3;
    st("w_active_keep", 4'h4, 2'd2, 1'b1, 1'b0);
    cfg_we = 1'b0;
    st("w_s3", 4'hB, 2'd3, 1'b1, 1'b0);
    st("w_done", 4'h0, 2'd0, 1'b0, 1'b1);
    st("w_idle", 4'h0, 2'd0, 1'b0, 1'b0);

    cfg(1'b0, 2'd3, 4'hF, 4'd0);
    abort = 1'b1; tick; abort = 1'b0; tick; tick;
    ex3("n3_idle", 4'h0, 2'd0, 1'b0, 1'b0);

    mode = 1'b1; start = 1'b1; tick; start = 1'b0;
    ex("new_s0", 4'h1, 2'd0, 1'b1, 1'b0);
    ex3("drop_s0", 4'h1, 2'd0, 1'b1, 1'b0);
    tick; tick;
    ex("new_s0c", 4'h1, 2'd0, 1'b1, 1'b0);
    ex3("drop_hold", 4'h1, 2'd0, 1'b1, 1'b0);
    tick;
    ex("new_s1", 4'h9, 2'd1, 1'b1, 1'b0);
    ex3("n3_s1", 4'h9, 2'd1, 1'b1, 1'b0);
    st("new_s2", 4'h3, 2'd2, 1'b1, 1'b0);
    ex3("n3_s2", 4'h3, 2'd2, 1'b1, 1'b0);
    st("new_s3", 4'hB, 2'd3, 1'b1, 1'b0);
    ex3("n3_done", 4'h0, 2'd0, 1'b0, 1'b1);
    st("new_done", 4'h0, 2'd0, 1'b0, 1'b1);
    st("new_idle", 4'h0, 2'd0, 1'b0, 1'b0);

    mode = 1'b0; start = 1'b1; st("f_s0", 4'h0, 2'd0, 1'b1, 1'b0); start = 1'b0;
    st("f_s1", 4'h2, 2'd1, 1'b1, 1'b0);
    st("f_s2", 4'hA, 2'd2, 1'b1, 1'b0);
    st("f_s3_new", 4'hF, 2'd3, 1'b1, 1'b0);
    st("f_done", 4'h0, 2'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
